// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants, state type and helpers for the memory-mapped UART transmitter.
// Register map, FSM encoding and STATUS bit positions live here so a future receiver can reuse them.
package mmio_uart_tx_pkg;

  localparam logic [11:0] IO_BASE     = 12'h001;
  localparam logic [1:0]  REG_TXDATA  = 2'd0;
  localparam logic [1:0]  REG_STATUS  = 2'd1;
  localparam logic [1:0]  REG_BAUDDIV = 2'd2;

  localparam int ST_EMPTY_BIT  = 0;
  localparam int ST_FULL_BIT   = 1;
  localparam int ST_BUSY_BIT   = 2;
  localparam int ST_OVF_BIT    = 3;
  localparam int ST_COUNT_LSB  = 4;
  localparam int ST_PARODD_BIT = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  function automatic logic [3:0] sat_count(input logic [31:0] n);
    return (n > 32'd15) ? 4'hF : n[3:0];
  endfunction

  // A programmed divisor of zero would stall the bit timer, so it behaves as one.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through output and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module mmio_uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter in the 0x001xxxxx I/O window with a TX FIFO.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits (STATUS[8] selects odd).
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DIV_RST = 16'd868
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DADDR,
  input  logic [3:0]  DMWE,
  input  logic        DMRE,
  input  logic [31:0] DATAI,
  output logic [31:0] DATAO,
  output logic        TXD,
  output logic        IRQ
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic [1:0]    reg_sel;
  logic          push_req;
  logic          ovf_set;
  logic          ovf_clr;
  logic          baud_wr;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;
  logic          fsm_pop;
  tx_state_e     state;
  tx_state_e     state_n;
  logic [15:0]   baud_cnt;
  logic [15:0]   cnt_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          bit_end;
  logic [15:0]   baud_div;
  logic [15:0]   div_eff;
  logic          ovf;
  logic [31:0]   status_val;
  logic [31:0]   rd_val;
  logic          unused_bits;
`ifdef UART_TX_PARITY_EN
  logic          par_odd;
  logic          par_bit;
  logic          par_bit_n;
`endif

  assign unused_bits = ^{DATAI[31:16], DMWE[3:2], DADDR[19:4], DADDR[1:0]};

  assign sel      = (DADDR[31:20] == IO_BASE);
  assign reg_sel  = DADDR[3:2];
  assign push_req = sel && (reg_sel == REG_TXDATA) && DMWE[0];
  assign ovf_clr  = sel && (reg_sel == REG_STATUS) && DMWE[0] && DATAI[ST_OVF_BIT];
  assign baud_wr  = sel && (reg_sel == REG_BAUDDIV);
  assign ovf_set  = push_req && fifo_full && !fsm_pop;
  assign div_eff  = eff_div(baud_div);
  assign bit_end  = (baud_cnt == 16'd1);
  assign IRQ      = fifo_empty && (state == TX_IDLE);

  mmio_uart_tx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_req),
    .pop   (fsm_pop),
    .din   (DATAI[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The baud counter reloads from the live divisor at every bit start, so a
  // divisor change lands on the next bit boundary.
  always_comb begin
    state_n = state;
    cnt_n   = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    fsm_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_bit_n = par_bit;
`endif
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fsm_pop = 1'b1;
          shreg_n = fifo_dout;
`ifdef UART_TX_PARITY_EN
          par_bit_n = ^fifo_dout;
`endif
          cnt_n   = div_eff;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cnt_n   = div_eff;
          bit_n   = 3'd0;
          state_n = TX_DATA;
        end else begin
          cnt_n = baud_cnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_n   = div_eff;
          shreg_n = shreg >> 1;
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = TX_PARITY;
`else
            state_n = TX_STOP;
`endif
          end
        end else begin
          cnt_n = baud_cnt - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          cnt_n   = div_eff;
          state_n = TX_STOP;
        end else begin
          cnt_n = baud_cnt - 16'd1;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fsm_pop = 1'b1;
            shreg_n = fifo_dout;
`ifdef UART_TX_PARITY_EN
            par_bit_n = ^fifo_dout;
`endif
            cnt_n   = div_eff;
            state_n = TX_START;
          end else begin
            state_n = TX_IDLE;
          end
        end else begin
          cnt_n = baud_cnt - 16'd1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= TX_IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
    end else begin
      state    <= state_n;
      baud_cnt <= cnt_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_bit <= 1'b0;
      par_odd <= 1'b0;
    end else begin
      par_bit <= par_bit_n;
      if (sel && (reg_sel == REG_STATUS) && DMWE[1]) par_odd <= DATAI[ST_PARODD_BIT];
    end
  end
`endif

  // TXD decodes straight from state so an asynchronous reset returns the line high at once.
  always_comb begin
    TXD = 1'b1;
    case (state)
      TX_START:  TXD = 1'b0;
      TX_DATA:   TXD = shreg[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: TXD = par_bit ^ par_odd;
`endif
      default:   TXD = 1'b1;
    endcase
  end

  // Overflow set takes priority over a simultaneous software clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_div <= BAUD_DIV_RST;
      ovf      <= 1'b0;
    end else begin
      if (baud_wr && DMWE[0]) baud_div[7:0]  <= DATAI[7:0];
      if (baud_wr && DMWE[1]) baud_div[15:8] <= DATAI[15:8];
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_comb begin
    status_val = '0;
    status_val[ST_EMPTY_BIT] = fifo_empty;
    status_val[ST_FULL_BIT]  = fifo_full;
    status_val[ST_BUSY_BIT]  = (state != TX_IDLE);
    status_val[ST_OVF_BIT]   = ovf;
    status_val[ST_COUNT_LSB +: 4] = sat_count(32'(fifo_count));
`ifdef UART_TX_PARITY_EN
    status_val[ST_PARODD_BIT] = par_odd;
`endif
  end

  always_comb begin
    rd_val = '0;
    if (sel) begin
      case (reg_sel)
        REG_STATUS:  rd_val = status_val;
        REG_BAUDDIV: rd_val = {16'd0, baud_div};
        default:     rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       DATAO <= '0;
    else if (DMRE) DATAO <= rd_val;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a frame-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mmio_uart_tx;

  localparam int          DEPTH   = 8;
  localparam logic [15:0] DIV_RST = 16'd868;
  localparam logic [31:0] A_TX  = 32'h0010_0000;
  localparam logic [31:0] A_ST  = 32'h0010_0004;
  localparam logic [31:0] A_BD  = 32'h0010_0008;
  localparam logic [31:0] A_R3  = 32'h0010_000C;
  localparam logic [31:0] A_OFF = 32'h0020_0008;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        CLK;
  logic        RST;
  logic [31:0] DADDR;
  logic [3:0]  DMWE;
  logic        DMRE;
  logic [31:0] DATAI;
  logic [31:0] DATAO;
  logic        TXD;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  // Model state: queued bytes plus the bit list of the frame on the wire.
  logic [7:0]  mq[$];
  bit          mActive;
  int          mBitIdx;
  int          mRem;
  bit          mBits[11];
  logic [15:0] mDiv;
  bit          mOvf;
  bit          mParOdd;
  logic [31:0] mDatao;
  int          effDiv;
  bit          mSel;
  logic [1:0]  mR;
  int          preSize;
  bit          popped;
  bit          ovfSet;
  logic [31:0] rv;

  mmio_uart_tx #(
    .FIFO_DEPTH   (DEPTH),
    .BAUD_DIV_RST (DIV_RST)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .DADDR (DADDR),
    .DMWE  (DMWE),
    .DMRE  (DMRE),
    .DATAI (DATAI),
    .DATAO (DATAO),
    .TXD   (TXD),
    .IRQ   (IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    int sz;
    sz = mq.size();
    s = '0;
    s[0] = (sz == 0);
    s[1] = (sz == DEPTH);
    s[2] = mActive;
    s[3] = mOvf;
    s[7:4] = (sz > 15) ? 4'hF : 4'(sz);
`ifdef UART_TX_PARITY_EN
    s[8] = mParOdd;
`endif
    return s;
  endfunction

  function automatic logic expTxd();
    return mActive ? mBits[mBitIdx] : 1'b1;
  endfunction

  task automatic startFrame(input int div);
    logic [7:0] b;
    b = mq.pop_front();
    mBits[0] = 1'b0;
    for (int i = 0; i < 8; i++) mBits[i + 1] = b[i];
`ifdef UART_TX_PARITY_EN
    mBits[9] = (^b) ^ mParOdd;
`endif
    mBits[NBITS - 1] = 1'b1;
    mActive = 1'b1;
    mBitIdx = 0;
    mRem    = div;
  endtask

  // Frame-level model: each pop builds the full bit list, each bit lasts the divisor in force at its start.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mq.delete();
      mActive = 1'b0;
      mBitIdx = 0;
      mRem    = 0;
      mDiv    = DIV_RST;
      mOvf    = 1'b0;
      mParOdd = 1'b0;
      mDatao  = '0;
    end else begin
      effDiv  = (mDiv == 16'd0) ? 1 : int'(mDiv);
      mSel    = (DADDR[31:20] == 12'h001);
      mR      = DADDR[3:2];
      preSize = mq.size();
      popped  = 1'b0;
      ovfSet  = 1'b0;
      rv      = '0;
      if (mSel && mR == 2'd1)      rv = modelStatus();
      else if (mSel && mR == 2'd2) rv = {16'h0, mDiv};
      if (DMRE) mDatao = rv;
      if (!mActive) begin
        if (preSize > 0) begin
          startFrame(effDiv);
          popped = 1'b1;
        end
      end else if (mRem > 1) begin
        mRem--;
      end else if (mBitIdx == NBITS - 1) begin
        if (preSize > 0) begin
          startFrame(effDiv);
          popped = 1'b1;
        end else begin
          mActive = 1'b0;
        end
      end else begin
        mBitIdx++;
        mRem = effDiv;
      end
      if (mSel && mR == 2'd0 && DMWE[0]) begin
        if (preSize < DEPTH || popped) mq.push_back(DATAI[7:0]);
        else ovfSet = 1'b1;
      end
      if (mSel && mR == 2'd1 && DMWE[0] && DATAI[3]) mOvf = 1'b0;
      if (ovfSet) mOvf = 1'b1;
`ifdef UART_TX_PARITY_EN
      if (mSel && mR == 2'd1 && DMWE[1]) mParOdd = DATAI[8];
`endif
      if (mSel && mR == 2'd2) begin
        if (DMWE[0]) mDiv[7:0]  = DATAI[7:0];
        if (DMWE[1]) mDiv[15:8] = DATAI[15:8];
      end
    end
  end

  always @(negedge CLK) begin
    checkOutput("model_txd", 32'(TXD), 32'(expTxd()));
    checkOutput("model_irq", 32'(IRQ), 32'((mq.size() == 0) && !mActive));
    checkOutput("model_datao", DATAO, mDatao);
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] we,
                               input logic re, input logic [31:0] data);
    DADDR = addr;
    DMWE  = we;
    DMRE  = re;
    DATAI = data;
    @(posedge CLK);
    #2;
    DADDR = '0;
    DMWE  = '0;
    DMRE  = 1'b0;
    DATAI = '0;
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(addr, 4'hF, 1'b0, data);
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    applyStimulus(addr, 4'h0, 1'b1, 32'h0);
    data = DATAO;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic waitIrq(input int budget, input string name);
    int n;
    n = 0;
    while (IRQ !== 1'b1 && n < budget) begin
      waitCycles(1);
      n++;
    end
    checkOutput(name, 32'(IRQ), 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    bit sawLow;
    RST   = 1'b1;
    DADDR = '0;
    DMWE  = '0;
    DMRE  = 1'b0;
    DATAI = '0;
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;

    $display("[TB] reset values and register map");
    checkOutput("rst_txd", 32'(TXD), 32'h1);
    checkOutput("rst_irq", 32'(IRQ), 32'h1);
    checkOutput("rst_datao", DATAO, 32'h0);
    readReg(A_BD, rd);  checkOutput("rst_bauddiv", rd, 32'h0000_0364);
    readReg(A_R3, rd);  checkOutput("reg3_read", rd, 32'h0);
    readReg(A_ST, rd);  checkOutput("rst_status", rd, 32'h0000_0001);
    readReg(A_BD, rd);
    readReg(A_OFF, rd); checkOutput("unsel_read", rd, 32'h0);
    readReg(A_TX, rd);  checkOutput("txdata_read", rd, 32'h0);
    writeReg(32'h0020_0000, 32'h77);
    waitCycles(2);
    checkOutput("unsel_store_irq", 32'(IRQ), 32'h1);

    $display("[TB] single frame 0x55 at divisor 4");
    writeReg(A_BD, 32'd4);
    writeReg(A_TX, 32'h55);
    checkOutput("t1_txd_store", 32'(TXD), 32'h1);
    checkOutput("t1_irq_queued", 32'(IRQ), 32'h0);
    waitCycles(1);
    checkOutput("t1_start_fall", 32'(TXD), 32'h0);
    waitCycles(3);
    checkOutput("t1_start_last", 32'(TXD), 32'h0);
    waitCycles(1);
    checkOutput("t1_bit0", 32'(TXD), 32'h1);
    readReg(A_ST, rd);
    checkOutput("t1_status_busy", rd, 32'h0000_0005);
    waitCycles(34);
    checkOutput("t1_stop_irq", 32'(IRQ), 32'h0);
    checkOutput("t1_stop_txd", 32'(TXD), 32'h1);
    waitCycles(1);
    checkOutput("t1_end_irq", 32'(IRQ), 32'h1);

    $display("[TB] overflow with ten back-to-back stores");
    writeReg(A_BD, 32'd100);
    for (int i = 0; i < 10; i++) writeReg(A_TX, 32'h10 + 32'(i));
    readReg(A_ST, rd);
    checkOutput("t2_status_full_ovf", rd, 32'h0000_008E);
    applyStimulus(A_ST, 4'hF, 1'b1, 32'h8);
    checkOutput("t2_rw_same_cycle", DATAO, 32'h0000_008E);
    readReg(A_ST, rd);
    checkOutput("t2_ovf_cleared", rd, 32'h0000_0086);

    $display("[TB] divisor change mid-frame and drain");
    writeReg(A_BD, 32'h2);
    readReg(A_BD, rd);
    checkOutput("t3_bauddiv", rd, 32'h2);
    waitIrq(2000, "t3_drain");

    $display("[TB] contiguous frames 0x41 0x42");
    writeReg(A_TX, 32'h41);
    writeReg(A_TX, 32'h42);
    waitCycles(19);
    checkOutput("t4_stop_first", 32'(TXD), 32'h1);
    waitCycles(1);
    checkOutput("t4_start_second", 32'(TXD), 32'h0);
    waitCycles(19);
    checkOutput("t4_busy_span", 32'(IRQ), 32'h0);
    waitCycles(1);
    checkOutput("t4_done", 32'(IRQ), 32'h1);

    $display("[TB] divisor zero behaves as one");
    writeReg(A_BD, 32'h0);
    readReg(A_BD, rd);
    checkOutput("t5_bauddiv_zero", rd, 32'h0);
    writeReg(A_TX, 32'hA5);
    waitCycles(10);
    checkOutput("t5_frame_active", 32'(IRQ), 32'h0);
    waitCycles(1);
    checkOutput("t5_frame_done", 32'(IRQ), 32'h1);

`ifndef UART_TX_PARITY_EN
    writeReg(A_ST, 32'h100);
    readReg(A_ST, rd);
    checkOutput("paritybit_ignored", rd, 32'h0000_0001);
`endif

    $display("[TB] reset mid-frame");
    writeReg(A_BD, 32'd4);
    writeReg(A_TX, 32'h07);
    writeReg(A_TX, 32'hA0);
    writeReg(A_TX, 32'h33);
    waitCycles(16);
    checkOutput("t6_bit3_low", 32'(TXD), 32'h0);
    RST = 1'b1;
    #1;
    checkOutput("t6_async_txd", 32'(TXD), 32'h1);
    checkOutput("t6_async_irq", 32'(IRQ), 32'h1);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    readReg(A_ST, rd);
    checkOutput("t6_status_after", rd, 32'h0000_0001);
    checkOutput("t6_irq_after", 32'(IRQ), 32'h1);
    sawLow = 1'b0;
    for (int i = 0; i < 60; i++) begin
      waitCycles(1);
      if (TXD !== 1'b1) sawLow = 1'b1;
    end
    checkOutput("t6_quiet_line", 32'(sawLow), 32'h0);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity even then odd");
    writeReg(A_BD, 32'd4);
    writeReg(A_TX, 32'h07);
    waitCycles(37);
    checkOutput("p_even_bit", 32'(TXD), 32'h1);
    waitIrq(100, "p_even_done");
    writeReg(A_ST, 32'h100);
    readReg(A_ST, rd);
    checkOutput("p_status_odd", rd, 32'h0000_0101);
    writeReg(A_TX, 32'h07);
    waitCycles(37);
    checkOutput("p_odd_bit", 32'(TXD), 32'h0);
    waitIrq(100, "p_odd_done");
`endif

    waitCycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
